// File: rtl/syn_csb_slave_if.sv
// Request/response signal bundle between a CSB master and the CSB register slave.
interface syn_csb_slave_if;
  logic        mcsb2scsb_pvld;
  logic        mcsb2scsb_prdy;
  logic [62:0] mcsb2scsb_pd;
  logic        scsb2mcsb_valid;
  logic [31:0] scsb2mcsb_pd;
  logic        scsb2mcsb_error;
  logic        scsb2mcsb_wr_complete;
  logic        scsb2mcsb_wr_err;
  logic        scsb2mcsb_wr_rdat;

  modport master (
    output mcsb2scsb_pvld, mcsb2scsb_pd,
    input  mcsb2scsb_prdy, scsb2mcsb_valid, scsb2mcsb_pd, scsb2mcsb_error,
           scsb2mcsb_wr_complete, scsb2mcsb_wr_err, scsb2mcsb_wr_rdat
  );

  modport slave (
    input  mcsb2scsb_pvld, mcsb2scsb_pd,
    output mcsb2scsb_prdy, scsb2mcsb_valid, scsb2mcsb_pd, scsb2mcsb_error,
           scsb2mcsb_wr_complete, scsb2mcsb_wr_err, scsb2mcsb_wr_rdat
  );
endinterface

// File: rtl/syn_csb_slave.sv
// CSB register-file slave: byte-enabled writes, fixed-latency read and
// non-posted write responses, one outstanding non-posted transaction.
module syn_csb_slave #(
  parameter int          NUM_REGS   = 16,
  parameter logic [21:0] BASE_ADDR  = 22'h0,
  parameter int          RD_LATENCY = 2,
  parameter int          WR_LATENCY = 1
) (
  input logic          clk,
  input logic          reset,
  syn_csb_slave_if.slave csb
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] data_q, data_nxt;
  logic        err_q, err_nxt;
  logic        rd_pulse, wr_pulse;

  logic [31:0] regs [NUM_REGS];

  logic [1:0]       req_level;
  logic [3:0]       req_wrbe;
  logic             req_srcpriv;
  logic             req_nposted;
  logic             req_write;
  logic [31:0]      req_wdat;
  logic [21:0]      req_addr;
  logic [21:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             hit;
  logic             accept;
  logic             unused_fields;

  assign {req_level, req_wrbe, req_srcpriv, req_nposted, req_write, req_wdat, req_addr} =
         csb.mcsb2scsb_pd;
  assign unused_fields = &{1'b0, req_level, req_srcpriv};

  // Offset arithmetic wraps at 22 bits, so addresses below BASE_ADDR miss.
  assign offset = req_addr - BASE_ADDR;
  assign idx    = offset[IDX_W-1:0];
  assign hit    = (offset < 22'(NUM_REGS));

  assign csb.mcsb2scsb_prdy    = (state == IDLE);
  assign csb.scsb2mcsb_wr_rdat = 1'b0;
  assign accept                = csb.mcsb2scsb_pvld & csb.mcsb2scsb_prdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else if (accept && req_write && hit) begin
      for (int b = 0; b < 4; b++)
        if (req_wrbe[b]) regs[idx][8*b +: 8] <= req_wdat[8*b +: 8];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data_q;
    err_nxt   = err_q;
    rd_pulse  = 1'b0;
    wr_pulse  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!req_write) begin
            state_nxt = RD_WAIT;
            cnt_nxt   = 4'(RD_LATENCY);
            data_nxt  = hit ? regs[idx] : 32'h0;
            err_nxt   = !hit;
          end else if (req_nposted) begin
            state_nxt = WR_WAIT;
            cnt_nxt   = 4'(WR_LATENCY);
            err_nxt   = !hit;
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        // The pulse is registered on the edge where the count hits 1, landing
        // exactly LATENCY cycles after the accepting edge.
        if (cnt == 4'd1) begin
          rd_pulse  = (state == RD_WAIT);
          wr_pulse  = (state == WR_WAIT);
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                     <= IDLE;
      cnt                       <= 4'd0;
      data_q                    <= 32'h0;
      err_q                     <= 1'b0;
      csb.scsb2mcsb_valid       <= 1'b0;
      csb.scsb2mcsb_pd          <= 32'h0;
      csb.scsb2mcsb_error       <= 1'b0;
      csb.scsb2mcsb_wr_complete <= 1'b0;
      csb.scsb2mcsb_wr_err      <= 1'b0;
    end else begin
      state                     <= state_nxt;
      cnt                       <= cnt_nxt;
      data_q                    <= data_nxt;
      err_q                     <= err_nxt;
      csb.scsb2mcsb_valid       <= rd_pulse;
      csb.scsb2mcsb_pd          <= rd_pulse ? data_q : 32'h0;
      csb.scsb2mcsb_error       <= rd_pulse & err_q;
      csb.scsb2mcsb_wr_complete <= wr_pulse;
      csb.scsb2mcsb_wr_err      <= wr_pulse & err_q;
    end
  end

endmodule

// File: doc/syn_csb_slave.md
SYN_CSB_SLAVE -- requirements
Module: syn_csb_slave

Interface
REQ-001 SHALL have parameter NUM_REGS, 16, number of 32-bit registers (1..1024).
REQ-002 SHALL have parameter BASE_ADDR, 22'h0, word address of register 0.
REQ-003 SHALL have parameter RD_LATENCY, 2, cycles from read accept to scsb2mcsb_valid (1..15).
REQ-004 SHALL have parameter WR_LATENCY, 1, cycles from non-posted write accept to scsb2mcsb_wr_complete (1..15).
REQ-005 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- mcsb2scsb_pvld  in  1  request valid.
- mcsb2scsb_prdy  out  1  request ready.
- mcsb2scsb_pd  in  63  request: [62:61] level, [60:57] wrbe, [56] srcpriv, [55] nposted, [54] write, [53:22] wdat, [21:0] addr.
- scsb2mcsb_valid  out  1  read response pulse.
- scsb2mcsb_pd  out  32  read data.
- scsb2mcsb_error  out  1  read error, qualified by valid.
- scsb2mcsb_wr_complete  out  1  non-posted write completion pulse.
- scsb2mcsb_wr_err  out  1  write error, qualified by wr_complete.
- scsb2mcsb_wr_rdat  out  1  reserved.

Function
REQ-006 SHALL accept a request on the rising clk edge when pvld=1 and prdy=1.
REQ-007 SHALL drive prdy=1 only in state IDLE; prdy SHALL be combinational from state.
REQ-008 SHALL implement states IDLE, RD_WAIT, WR_WAIT.
REQ-009 SHALL compute offset = addr - BASE_ADDR (22-bit, modulo) and hit = (offset < NUM_REGS).
REQ-010 On a write, hit, SHALL update each byte i of reg[offset] from wdat[8i+7:8i] when wrbe[i]=1; bytes with wrbe[i]=0 SHALL be unchanged; update SHALL occur at the accepting edge.
REQ-011 On a write, miss, SHALL leave the register file unchanged.
REQ-012 On a posted write (write=1, nposted=0), SHALL remain in IDLE and SHALL produce no response.
REQ-013 On a non-posted write, SHALL go to WR_WAIT, load counter with WR_LATENCY, and latch err = !hit.
REQ-014 On a read (write=0), SHALL go to RD_WAIT, load counter with RD_LATENCY, and latch data = hit ? reg[offset] : 0 and err = !hit.
REQ-015 In RD_WAIT/WR_WAIT, counter SHALL decrement each cycle; scsb2mcsb_valid/wr_complete SHALL assert on the cycle counter=1, then state returns to IDLE.
REQ-016 The response SHALL appear exactly RD_LATENCY (resp. WR_LATENCY) cycles after the accepting edge.
REQ-017 Each response SHALL be a single-cycle registered pulse; pd/error/wr_err SHALL be valid only in that cycle and 0 otherwise.
REQ-018 A new request SHALL be acceptable in the cycle after the response pulse (prdy=1 in IDLE).
REQ-019 Back-to-back posted writes SHALL be accepted every cycle.
REQ-020 A read accepted the cycle after a posted write to the same register SHALL return the post-write value.
REQ-021 level and srcpriv SHALL be ignored.
REQ-022 scsb2mcsb_wr_rdat SHALL be tied to 0.
REQ-023 Only one non-posted transaction SHALL be outstanding; pvld while not in IDLE SHALL be ignored (prdy=0).

Reset
REQ-024 reset=0 SHALL asynchronously force state IDLE, counter 0, all registers 0, and all response outputs to 0.
REQ-025 mcsb2scsb_prdy SHALL be 1 during reset (state IDLE).
REQ-026 Reset asserted in RD_WAIT/WR_WAIT SHALL abort the transaction with no response pulse.

Verification
REQ-027 Posted write addr=BASE_ADDR+3, wrbe=4'hF, wdat=32'hDEADBEEF, then read addr=BASE_ADDR+3 -> valid pulse after RD_LATENCY cycles, pd=32'hDEADBEEF, error=0.
REQ-028 Posted write wrbe=4'b0101, wdat=32'h11223344 over reg=32'hDEADBEEF, then read -> pd=32'hDE22BE44.
REQ-029 Non-posted write addr=BASE_ADDR+NUM_REGS -> wr_complete after WR_LATENCY cycles with wr_err=1; a subsequent read of every register shows no change.
REQ-030 Read addr=BASE_ADDR-1 (wraps) -> valid=1, error=1, pd=0.
REQ-031 pvld held high continuously during RD_WAIT -> prdy=0 and no second accept until the cycle after valid.
REQ-032 Reset pulsed while in RD_WAIT -> no valid pulse; all registers read back 0 after reset.
